// File: rtl/seg7_bin_encoder_scan.sv
// seg7_bin_encoder_scan: binary-to-BCD (double-dabble) to 7-seg encoder with a one-hot digit scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero one.
module seg7_bin_encoder_scan #(
  parameter int N_DIGITS = 4,
  parameter int VAL_W    = 14,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VAL_W-1:0]      in_value,
  output logic [8*N_DIGITS-1:0] seg_word,
  output logic                  ovf,
  output logic                  busy,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   dig_sel
);
  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                state_q, state_d;
  logic [VAL_W-1:0]      bin_q, bin_d;
  logic [BW-1:0]         bcd_q, bcd_d, adj;
  logic                  cout_q, cout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8*N_DIGITS-1:0] seg_q, seg_d, enc;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  blank;
`endif

  function automatic logic [7:0] code(input logic [3:0] n);
    case (n)
      4'd0: code = 8'h3F;
      4'd1: code = 8'h06;
      4'd2: code = 8'h5B;
      4'd3: code = 8'h4F;
      4'd4: code = 8'h66;
      4'd5: code = 8'h6D;
      4'd6: code = 8'h7D;
      4'd7: code = 8'h07;
      4'd8: code = 8'h7F;
      4'd9: code = 8'h6F;
      default: code = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    adj     = bcd_q;
    enc     = '0;
`ifdef LEADING_ZERO_BLANK_EN
    blank   = 1'b1;
`endif
    for (int i = 0; i < N_DIGITS; i++)
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    // Walk from the most significant digit so blanking stops at the first nonzero one.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_q[4*i+:4] != 4'd0 || i == 0) blank = 1'b0;
      enc[8*i+:8] = blank ? 8'h00 : code(bcd_q[4*i+:4]);
`else
      enc[8*i+:8] = code(bcd_q[4*i+:4]);
`endif
    end
    case (state_q)
      IDLE: if (in_valid) begin
        bin_d   = in_value;
        bcd_d   = '0;
        cout_d  = 1'b0;
        cnt_d   = CW'(VAL_W);
        state_d = CONV;
      end
      CONV: begin
        {bcd_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cout_d  = cout_q | adj[BW-1];
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? LOAD : CONV;
      end
      LOAD: begin
        seg_d   = cout_q ? {N_DIGITS{8'h40}} : enc;
        ovf_d   = cout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pre_d = pre_q == PW'(SCAN_DIV - 1) ? '0 : pre_q + 1'b1;
    idx_d = pre_q != PW'(SCAN_DIV - 1) ? idx_q : idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= '0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign seg_word = seg_q;
  assign ovf      = ovf_q;
  assign dig_sel  = N_DIGITS'(1) << idx_q;
  assign seg_out  = 8'(seg_q >> {idx_q, 3'b000});
endmodule

// File: doc/seg7_bin_encoder_scan.md
Name: seg7_bin_encoder_scan

Overview:
Producer side of the 7-segment datapath. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It encodes each digit into the team's 8-bit segment code, which is the same code the 7-seg adder consumes. The block presents all digit codes in parallel and also time-multiplexes them onto one physical segment bus with a one-hot digit select.

Parameters:
N_DIGITS, 4, number of decimal digits displayed/encoded
VAL_W, 14, width of binary input value
SCAN_DIV, 1000, clk cycles each digit stays selected during scanning (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  in_value is offered
in_ready  output  1  block can accept a new value (high only in IDLE)
in_value  input  VAL_W  unsigned binary value to display
seg_word  output  8*N_DIGITS  latched segment codes; byte i = digit i, digit 0 = least significant
ovf  output  1  last accepted value exceeded 10^N_DIGITS-1
busy  output  1  conversion in progress (state != IDLE)
seg_out  output  8  segment code of currently scanned digit
dig_sel  output  N_DIGITS  one-hot select of scanned digit; bit i = digit i

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Segment code: bit0=a … bit6=g, bit7=dp, 1 = segment lit.
- Digit codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Dash = 0x40. Blank = 0x00. dp is always 0.
- Reset values: in_ready=1, busy=0, ovf=0, seg_word=all 0x00, scan index=0, prescaler=0, dig_sel=1 (digit 0), seg_out=0x00.
- FSM states: IDLE, CONV, LOAD.
- IDLE: in_ready=1. On a clk edge with in_valid=1:
  - capture in_value into the shift register;
  - clear the BCD register (4*N_DIGITS bits) and the carry-out flag;
  - set the iteration counter to VAL_W; go to CONV.
  - in_valid=0 leaves IDLE unchanged.
- CONV: once per clk:
  - add 3 to every BCD nibble >=5;
  - shift {BCD, bin} left by 1;
  - if the bit shifted out of the BCD top is 1, set the carry-out flag (sticky);
  - decrement the counter. After VAL_W shifts, go to LOAD.
- LOAD (one cycle):
  - if carry-out is set: ovf=1 and every byte of seg_word = 0x40;
  - else: ovf=0 and byte i = code(BCD nibble i);
  - go to IDLE.
- Latency: value accepted at edge k → seg_word/ovf updated at edge k+VAL_W+1. in_ready is high again from that edge.
- Outputs hold between updates. seg_word and ovf change only in LOAD.
- in_valid while busy: ignored; no queuing. The producer must hold in_valid until in_ready is high.
- Reset mid-conversion: abort immediately. All outputs go to reset values and the pending value is lost.
- Scanner (independent of the FSM, runs continuously):
  - the prescaler counts 0..SCAN_DIV-1;
  - on wrap, scan index = (index+1) mod N_DIGITS;
  - dig_sel = 1<<index; seg_out = byte index of seg_word (combinational from registered index);
  - SCAN_DIV=1 advances the index every cycle.
- Exactly one dig_sel bit is high at all times, including during reset.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in LOAD (non-ovf case), every digit more significant than the highest nonzero digit gets 0x00. Digit 0 always shows its code, so value 0 shows 0x3F in digit 0 only.
- Undefined: all digits are encoded, leading zeros included.
- ovf display is unaffected in both cases.

Test Plan (N_DIGITS=4, VAL_W=14, SCAN_DIV=4):
- Convert 1234: in_value=1234 with in_valid pulse at edge k → seg_word=0x065B4F66 and ovf=0 at edge k+15; in_ready=0 for edges k+1..k+14.
- Overflow: in_value=12345 → ovf=1, seg_word=0x40404040. Then in_value=7 → ovf=0, seg_word=0x3F3F3F07 (0x00000007 with LEADING_ZERO_BLANK_EN).
- Zero and max: in_value=0 → 0x3F3F3F3F (0x0000003F with LEADING_ZERO_BLANK_EN). in_value=9999 → 0x6F6F6F6F, ovf=0.
- Busy drop: accept 56; at edge k+3 present 89 with in_valid=1 → seg_word=0x3F3F6D7D and no later update for 89 unless it is re-presented while in_ready=1.
- Reset mid-operation: assert rst at k+5 during the conversion of 4321 → immediate seg_word=0, ovf=0, dig_sel=0001, seg_out=0x00. After release, in_ready=1 and no late update occurs.
- Scan: after loading 1234, dig_sel = 0001, 0010, 0100, 1000 for 4 cycles each, with seg_out = 0x66, 0x4F, 0x5B, 0x06. It returns to 0001 after 16 cycles.
